// File: rtl/hyperbola_rotation_iter_pkg.sv
// hyperbola_rotation_iter_pkg: shared constants, FSM states and atanh table source for the hyperbolic CORDIC
package hyperbola_rotation_iter_pkg;
  localparam real ZMAX = 1.1;
  localparam real INV_KH = 1.2074970677630;
  localparam int REP1 = 4;
  localparam int REP2 = 13;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic real atanh_pow2(input int i);
    case (i)
      1: atanh_pow2 = 0.5493061443340549;
      2: atanh_pow2 = 0.2554128118829953;
      3: atanh_pow2 = 0.1256572141404530;
      4: atanh_pow2 = 0.0625815714770030;
      5: atanh_pow2 = 0.0312601784906670;
      6: atanh_pow2 = 0.0156262717520522;
      7: atanh_pow2 = 0.0078126589515404;
      8: atanh_pow2 = 0.0039062698683968;
      9: atanh_pow2 = 0.0019531274835326;
      10: atanh_pow2 = 0.0009765628104410;
      11: atanh_pow2 = 0.00048828128880511;
      12: atanh_pow2 = 0.00024414062985063;
      13: atanh_pow2 = 0.00012207031310633;
      14: atanh_pow2 = 0.000061035156325791;
      15: atanh_pow2 = 0.000030517578134474;
      16: atanh_pow2 = 0.000015258789063684;
      17: atanh_pow2 = 0.0000076293945313980;
      18: atanh_pow2 = 0.0000038146972656435;
      19: atanh_pow2 = 0.0000019073486328148;
      20: atanh_pow2 = 0.00000095367431640914;
      default: atanh_pow2 = 0.0;
    endcase
  endfunction
endpackage

// File: rtl/hyperbola_atanh_rom.sv
// hyperbola_atanh_rom: combinational lookup of atanh(2^-i) in the Z fixed-point format
module hyperbola_atanh_rom
  import hyperbola_rotation_iter_pkg::*;
#(
  parameter int W = 21,
  parameter int FB = 18
) (
  input  logic [4:0]          idx,
  output logic signed [W-1:0] val
);
  logic signed [W-1:0] tbl [32];
  for (genvar k = 0; k < 32; k++) begin : g_tbl
    localparam logic signed [W-1:0] E = W'($rtoi(atanh_pow2(k) * 2.0 ** FB + 0.5));
    assign tbl[k] = E;
  end
  assign val = tbl[idx];
endmodule

// File: rtl/hyperbola_rotation_iter.sv
// hyperbola_rotation_iter: iterative hyperbolic CORDIC, rotation mode, produces cosh(z) and sinh(z)
module hyperbola_rotation_iter
  import hyperbola_rotation_iter_pkg::*;
#(
  parameter int DSIZE = 17,
  parameter int NITER = 16,
  parameter int GUARD = 3
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] IZ,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] OX,
  output logic [DSIZE-1:0] OY,
  output logic             out_ovf
);
  localparam int W = DSIZE + GUARD + 1;
  localparam int FX = DSIZE - 1 + GUARD;
  localparam int FZ = DSIZE - 2 + GUARD;
  localparam int STEPS = NITER + 2;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic signed [W-1:0] X0 = W'($rtoi(INV_KH * 2.0 ** FX + 0.5));
  localparam logic signed [W-1:0] ZMAX_Z = W'($rtoi(ZMAX * 2.0 ** FZ + 0.5));
  localparam logic signed [DSIZE-1:0] ZMAX_IZ = DSIZE'($rtoi(ZMAX * 2.0 ** (DSIZE - 2)));
  localparam logic signed [W-1:0] OX_MAX = W'((1 << DSIZE) - 1);
  localparam logic signed [W-1:0] OY_MAX = W'((1 << (DSIZE - 1)) - 1);
  localparam logic signed [W-1:0] OY_MIN = ~OY_MAX;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] sh;
  logic signed [W-1:0] x, y, z, xn, yn, zn, ang, z0, ox_t, oy_t;
  logic signed [DSIZE-1:0] iz_s;
  logic ovf_in;
  logic [DSIZE-1:0] ox_sat, oy_sat;
  hyperbola_atanh_rom #(.W(W), .FB(FZ)) u_rom (.idx(sh), .val(ang));
  // X and Y carry one more fraction bit than Z so cosh keeps full output precision
  always_comb begin
    sh = 5'(cnt) + 5'd1 - 5'(cnt >= CW'(REP1)) - 5'(cnt > CW'(REP2));
    iz_s = signed'(IZ);
    ovf_in = (iz_s > ZMAX_IZ) || (iz_s < -ZMAX_IZ);
    z0 = iz_s > ZMAX_IZ ? ZMAX_Z : iz_s < -ZMAX_IZ ? -ZMAX_Z : W'(iz_s) <<< GUARD;
    xn = z[W-1] ? x - (y >>> sh) : x + (y >>> sh);
    yn = z[W-1] ? y - (x >>> sh) : y + (x >>> sh);
    zn = z[W-1] ? z + ang : z - ang;
    ox_t = xn >>> GUARD;
    oy_t = yn >>> (GUARD + 1);
    ox_sat = ox_t < 0 ? '0 : ox_t > OX_MAX ? '1 : DSIZE'(ox_t);
    oy_sat = oy_t > OY_MAX ? DSIZE'(OY_MAX) : oy_t < OY_MIN ? DSIZE'(OY_MIN) : DSIZE'(oy_t);
  end
  // control FSM with datapath registers; outputs are captured on the final micro-rotation
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      OX <= '0;
      OY <= '0;
      out_ovf <= 1'b0;
      cnt <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= X0;
          y <= '0;
          z <= z0;
          out_ovf <= ovf_in;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          x <= xn;
          y <= yn;
          z <= zn;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) begin
            OX <= ox_sat;
            OY <= oy_sat;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbola_rotation_iter.sv
// tb_hyperbola_rotation_iter: directed and random checks of cosh/sinh against a real-valued model
module tb_hyperbola_rotation_iter;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [16:0] IZ = '0;
  logic in_ready, out_valid, out_ovf;
  logic [16:0] OX, OY;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  hyperbola_rotation_iter #(.DSIZE(17), .NITER(16), .GUARD(3)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .IZ(IZ),
    .out_valid(out_valid), .out_ready(out_ready), .OX(OX), .OY(OY), .out_ovf(out_ovf)
  );
  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_tol(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (((obs - exp) <= 4 && (exp - obs) <= 4) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (+/-4)", tag, obs, exp);
    end
  endtask
  task automatic model(input int iz, output int ex, output int ey, output logic eo);
    real zr;
    zr = iz / 32768.0;
    eo = (zr > 1.1) || (zr < -1.1);
    zr = zr > 1.1 ? 1.1 : zr < -1.1 ? -1.1 : zr;
    ex = int'($floor(($exp(zr) + $exp(-zr)) / 2.0 * 65536.0));
    ey = int'($floor(($exp(zr) - $exp(-zr)) / 2.0 * 32768.0));
  endtask
  task automatic do_op(input int iz, input int hold, input string tag);
    int ex, ey, lat;
    logic eo;
    logic [16:0] fx, fy;
    model(iz, ex, ey, eo);
    @(negedge clock);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    IZ = 17'(iz);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      IZ = 17'($urandom);
      @(negedge clock);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 18);
    check_eq({tag, "_in_ready_done"}, in_ready, 0);
    check_tol({tag, "_ox"}, OX, ex);
    check_tol({tag, "_oy"}, longint'(signed'(OY)), ey);
    check_eq({tag, "_ovf"}, out_ovf, eo);
    fx = OX;
    fy = OY;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      IZ = 17'($urandom);
      @(negedge clock);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
      check_eq({tag, "_hold_ox"}, OX, fx);
      check_eq({tag, "_hold_oy"}, OY, fy);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_in_ready_back"}, in_ready, 1);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clock);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_ox", OX, 0);
    check_eq("rst_oy", OY, 0);
    check_eq("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    do_op(0, 0, "zero");
    do_op(16384, 0, "pos_half");
    do_op(-16384, 0, "neg_half");
    do_op(32767, 0, "one");
    do_op(-65536, 10, "neg_min");
    do_op(36044, 0, "zmax_pos");
    do_op(-36044, 0, "zmax_neg");
    do_op(36045, 3, "over_pos");
    do_op(65535, 0, "max_code");
    @(negedge clock);
    in_valid = 1'b1;
    IZ = 17'(16384);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_ox", OX, 0);
    @(negedge clock);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      seen = seen | int'(out_valid);
    end
    check_eq("abort_no_emit", seen, 0);
    check_eq("abort_in_ready_after", in_ready, 1);
    do_op(-16384, 0, "after_abort");
    for (int k = 0; k < 10; k++) do_op(int'($urandom_range(0, 72088)) - 36044, k % 3, "rand_legal");
    for (int k = 0; k < 4; k++) do_op(int'($urandom_range(0, 131071)) - 65536, 0, "rand_full");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
